// File: rtl/dcache_refill_ctrl_pkg.sv
// Shared types, width helpers and default sizes for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int DEF_WD   = 32;
  localparam int DEF_AW   = 32;
  localparam int DEF_SETS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dcache_state_e;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Lines are one word wide, so two byte-offset bits sit below the index.
  function automatic int tag_w(input int aw, input int sets);
    return aw - $clog2(sets) - 2;
  endfunction

endpackage

// File: rtl/dcache_refill_ctrl_array.sv
// Valid/tag/data storage: combinational read at one index, one synchronous write port.
// Reset clears only the valid bits; tag and data contents survive.
module dcache_array #(
  parameter int WD   = 32,
  parameter int TW   = 24,
  parameter int SETS = 64,
  parameter int IW   = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [WD-1:0] rd_data,
  input  logic          wr_en,
  input  logic          wr_fill,
  input  logic [IW-1:0] wr_idx,
  input  logic [TW-1:0] wr_tag,
  input  logic [WD-1:0] wr_data
);

  logic [SETS-1:0] valid_q;
  logic [TW-1:0]   tag_q  [SETS];
  logic [WD-1:0]   data_q [SETS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // A fill writes tag and data; a store hit writes data only.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[wr_idx] <= wr_data;
      if (wr_fill) begin
        tag_q[wr_idx] <= wr_tag;
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Direct-mapped write-through data cache controller: lookup, miss refill, store write-through.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int WD   = DEF_WD,
  parameter int AW   = DEF_AW,
  parameter int SETS = DEF_SETS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_re,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [WD-1:0] cpu_wdata,
  output logic          stall,
  output logic          hit,
  output logic [WD-1:0] cache_rdata,
  output logic [WD-1:0] mem_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [WD-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [WD-1:0] mem_rdata_in,
`ifdef DCACHE_STATS_EN
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt,
`endif
  output dcache_state_e dbg_state
);

  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(AW, SETS);

  // Handshake: mem_req/mem_we/mem_addr/mem_wdata stay stable from the first
  // request cycle through the cycle mem_ack is high; the request drops the cycle after.

  dcache_state_e state_q, state_d;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic          raw_hit;
  logic          arr_wr_en;
  logic          arr_wr_fill;
  logic [WD-1:0] arr_wr_data;
  logic          unused_addr_bits;

  assign idx              = cpu_addr[IW+1:2];
  assign tag              = cpu_addr[AW-1:IW+2];
  assign raw_hit          = rd_valid && (rd_tag == tag);
  assign unused_addr_bits = ^cpu_addr[1:0];
  assign mem_addr         = {cpu_addr[AW-1:2], 2'b00};
  assign mem_wdata        = cpu_wdata;
  assign dbg_state        = state_q;

  dcache_array #(
    .WD   (WD),
    .TW   (TW),
    .SETS (SETS),
    .IW   (IW)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (cache_rdata),
    .wr_en    (arr_wr_en),
    .wr_fill  (arr_wr_fill),
    .wr_idx   (idx),
    .wr_tag   (tag),
    .wr_data  (arr_wr_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_we) begin
          state_d = WRITE;
        end else if (cpu_re && !raw_hit) begin
          state_d = FETCH;
        end
      end
      FETCH:   if (mem_ack) state_d = RESP;
      WRITE:   if (mem_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array writes are gated by rst_n so an ack landing on the reset edge cannot fill a line.
  always_comb begin
    stall       = 1'b0;
    hit         = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    arr_wr_en   = 1'b0;
    arr_wr_fill = 1'b0;
    arr_wr_data = cpu_wdata;
    case (state_q)
      IDLE: begin
        stall = cpu_we || (cpu_re && !raw_hit);
        hit   = raw_hit && cpu_re && !cpu_we;
      end
      FETCH: begin
        stall       = 1'b1;
        mem_req     = 1'b1;
        arr_wr_en   = rst_n && mem_ack;
        arr_wr_fill = 1'b1;
        arr_wr_data = mem_rdata_in;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        arr_wr_en = rst_n && mem_ack && raw_hit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rdata <= '0;
    end else if (state_q == FETCH && mem_ack) begin
      mem_rdata <= mem_rdata_in;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != 32'hFFFF_FFFF) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (state_q == IDLE && state_d == FETCH && miss_cnt != 32'hFFFF_FFFF) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed self-checking bench for dcache_refill_ctrl (SETS=64, one-word lines).
module tb_dcache_refill_ctrl;
  import dcache_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          cpu_re;
  logic          cpu_we;
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          stall;
  logic          hit;
  logic [31:0]   cache_rdata;
  logic [31:0]   mem_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata_in;
  dcache_state_e dbg_state;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  dcache_refill_ctrl #(.WD(32), .AW(32), .SETS(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .stall        (stall),
    .hit          (hit),
    .cache_rdata  (cache_rdata),
    .mem_rdata    (mem_rdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata_in (mem_rdata_in),
`ifdef DCACHE_STATS_EN
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Full miss/store transaction: memory acks in the n-th request cycle.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int n, input logic [31:0] exp_mrd);
    int stalls;
    stalls    = 0;
    cpu_re    = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    @(negedge clk);
    chkb("idle_stall", stall, 1'b1);
    chkb("idle_hit", hit, 1'b0);
    chkb("idle_req", mem_req, 1'b0);
    stalls += int'(stall);
    for (int i = 1; i <= n; i++) begin
      next_cycle();
      mem_ack      = (i == n);
      mem_rdata_in = (i == n) ? rdata : 32'h0BAD_0BAD;
      @(negedge clk);
      chkb("req", mem_req, 1'b1);
      chkb("req_we", mem_we, we);
      chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
      if (we) chk("req_wdata", mem_wdata, wdata);
      chkb("req_hit", hit, 1'b0);
      chk("req_state", 32'(dbg_state), we ? 32'(WRITE) : 32'(FETCH));
      stalls += int'(stall);
    end
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("resp_state", 32'(dbg_state), 32'(RESP));
    chkb("resp_stall", stall, 1'b0);
    chkb("resp_hit", hit, 1'b0);
    chkb("resp_req", mem_req, 1'b0);
    chk("resp_mem_rdata", mem_rdata, exp_mrd);
    stalls += int'(stall);
    chk("stall_cycles", stalls, n + 1);
    next_cycle();
    cpu_re = 1'b0;
    cpu_we = 1'b0;
  endtask

  task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp);
    cpu_re   = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = addr;
    @(negedge clk);
    chkb("lh_hit", hit, 1'b1);
    chk("lh_data", cache_rdata, exp);
    chkb("lh_stall", stall, 1'b0);
    chkb("lh_req", mem_req, 1'b0);
    next_cycle();
    cpu_re = 1'b0;
    @(negedge clk);
    chk("lh_state", 32'(dbg_state), 32'(IDLE));
    next_cycle();
  endtask

  initial begin
    rst_n        = 1'b0;
    cpu_re       = 1'b0;
    cpu_we       = 1'b0;
    cpu_addr     = '0;
    cpu_wdata    = '0;
    mem_ack      = 1'b0;
    mem_rdata_in = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_hit", hit, 1'b0);
    chkb("rst_req", mem_req, 1'b0);
    chkb("rst_we", mem_we, 1'b0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
    next_cycle();

    // Cold miss at 0x100, ack 3 cycles in
    txn(1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF);
    // Low address bits are ignored on lookup
    load_hit(32'h103, 32'hDEAD_BEEF);
    // Store with simultaneous cpu_re: store wins, write-through to the hit line
    txn(1'b1, 32'h100, 32'hCAFE_F00D, 32'h0, 1, 32'hDEAD_BEEF);
    load_hit(32'h100, 32'hCAFE_F00D);
    // Same-index conflict: 0x200 evicts 0x100, which then misses again
    txn(1'b0, 32'h200, 32'h0, 32'h1111_1111, 2, 32'h1111_1111);
    load_hit(32'h200, 32'h1111_1111);
    txn(1'b0, 32'h100, 32'h0, 32'h3333_3333, 1, 32'h3333_3333);
    // Store miss: memory only, line at the index untouched
    txn(1'b1, 32'h300, 32'h7777_7777, 32'h0, 2, 32'h3333_3333);
    load_hit(32'h100, 32'h3333_3333);
    txn(1'b0, 32'h300, 32'h0, 32'h4444_4444, 1, 32'h4444_4444);
`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("pre_hit_cnt", hit_cnt, 32'd4);
    chk("pre_miss_cnt", miss_cnt, 32'd4);
    next_cycle();
`endif

    // Reset in the middle of a refill, then a stale ack
    cpu_re   = 1'b1;
    cpu_addr = 32'h100;
    @(negedge clk);
    chkb("ab_stall", stall, 1'b1);
    next_cycle();
    @(negedge clk);
    chkb("ab_req", mem_req, 1'b1);
    next_cycle();
    rst_n  = 1'b0;
    cpu_re = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chkb("ab_req_after_rst", mem_req, 1'b0);
    chk("ab_state", 32'(dbg_state), 32'(IDLE));
    next_cycle();
    next_cycle();
    mem_ack      = 1'b1;
    mem_rdata_in = 32'h5555_5555;
    @(negedge clk);
    chkb("stale_ack_req", mem_req, 1'b0);
    chkb("stale_ack_stall", stall, 1'b0);
    next_cycle();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stale_ack_mem_rdata", mem_rdata, 32'h0);
    chk("stale_ack_state", 32'(dbg_state), 32'(IDLE));
`ifdef DCACHE_STATS_EN
    chk("post_hit_cnt", hit_cnt, 32'd0);
    chk("post_miss_cnt", miss_cnt, 32'd0);
`endif
    next_cycle();
    // Valid bits were cleared: previously cached 0x300 and 0x100 both miss
    txn(1'b0, 32'h300, 32'h0, 32'h6666_6666, 2, 32'h6666_6666);
    txn(1'b0, 32'h100, 32'h0, 32'h8888_8888, 1, 32'h8888_8888);
    load_hit(32'h100, 32'h8888_8888);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
